// File: rtl/seq_recorder_if.sv
// rtl/seq_recorder_if.sv - sequence RAM port A write bus between recorder and RAM
interface seq_recorder_if;
   logic [9:0] address_a;
   logic [9:0] data_a;
   logic       wren_a;

   modport master (output address_a, data_a, wren_a);
   modport slave  (input  address_a, data_a, wren_a);
endinterface

// File: rtl/seq_recorder.sv
// rtl/seq_recorder.sv - records debounced switch words into the sequence RAM, one step per press
// Address layout {seq_num, step} matches the sequencer's read side.
module seq_recorder #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic                  CLK_50,
   input  logic                  reset,
   input  logic [5:0]            seq_num,
   input  logic [9:0]            SW,
   input  logic                  pb_rec,
   input  logic                  pb_clr,
   seq_recorder_if.master        ram,
   output logic [3:0]            step_num,
   output logic                  busy,
   output logic                  done
);

   localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_t;

   // Bit 0 is the record button, bit 1 the clear button.
   logic [1:0]         raw;
   logic [1:0]         s1_q, s2_q;
   logic [1:0]         db_q, db_d;
   logic [1:0]         press_q, press_d;
   logic [1:0][CW-1:0] cnt_q, cnt_d;
   logic               rec_p, clr_p;

   state_t     state_q, state_d;
   logic [5:0] seq_lat_q, seq_lat_d, seq_prev_q;
   logic [3:0] step_q, step_d, k_q, k_d, step_idle;
   logic [9:0] addr_q, addr_d, data_q, data_d;
   logic       wren_q, wren_d, busy_q, busy_d, done_q, done_d;

   assign raw   = {pb_clr, pb_rec};
   assign rec_p = press_q[0];
   assign clr_p = press_q[1];

   always_comb begin
      db_d  = db_q;
      cnt_d = '0;
      for (int i = 0; i < 2; i++) begin
         if (s2_q[i] != db_q[i]) begin
            if (cnt_q[i] == CNT_LAST) db_d[i] = s2_q[i];
            else                      cnt_d[i] = cnt_q[i] + 1'b1;
         end
      end
      // Only falling edges of the debounced level count as presses.
      press_d = db_q & ~db_d;
   end

   always_comb begin
      state_d   = state_q;
      seq_lat_d = seq_lat_q;
      step_d    = step_q;
      k_d       = k_q;
      addr_d    = addr_q;
      data_d    = data_q;
      wren_d    = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      step_idle = (seq_num != seq_prev_q) ? 4'd0 : step_q;
      case (state_q)
         IDLE: begin
            step_d = step_idle;
            if (clr_p) begin
               state_d   = CLEAR;
               seq_lat_d = seq_num;
               step_d    = 4'd0;
               k_d       = 4'd0;
               addr_d    = {seq_num, 4'd0};
               data_d    = '0;
               wren_d    = 1'b1;
               busy_d    = 1'b1;
            end else if (rec_p) begin
               state_d   = WRITE;
               seq_lat_d = seq_num;
               addr_d    = {seq_num, step_idle};
               data_d    = SW;
               wren_d    = 1'b1;
            end
         end
         WRITE: begin
            step_d  = step_q + 4'd1;
            done_d  = (step_q == 4'd15);
            state_d = IDLE;
         end
         CLEAR: begin
            if (k_q == 4'd15) begin
               state_d = IDLE;
               done_d  = 1'b1;
               step_d  = 4'd0;
            end else begin
               k_d    = k_q + 4'd1;
               addr_d = {seq_lat_q, k_q + 4'd1};
               data_d = '0;
               wren_d = 1'b1;
               busy_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK_50 or negedge reset) begin
      if (!reset) begin
         s1_q       <= '1;
         s2_q       <= '1;
         db_q       <= '1;
         cnt_q      <= '0;
         press_q    <= '0;
         state_q    <= IDLE;
         seq_lat_q  <= '0;
         seq_prev_q <= '0;
         step_q     <= '0;
         k_q        <= '0;
         addr_q     <= '0;
         data_q     <= '0;
         wren_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         s1_q       <= raw;
         s2_q       <= s1_q;
         db_q       <= db_d;
         cnt_q      <= cnt_d;
         press_q    <= press_d;
         state_q    <= state_d;
         seq_lat_q  <= seq_lat_d;
         seq_prev_q <= seq_num;
         step_q     <= step_d;
         k_q        <= k_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         wren_q     <= wren_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign ram.address_a = addr_q;
   assign ram.data_a    = data_q;
   assign ram.wren_a    = wren_q;
   assign step_num      = step_q;
   assign busy          = busy_q;
   assign done          = done_q;

endmodule

// File: tb/tb_seq_recorder.sv
// tb/tb_seq_recorder.sv - randomized bench for seq_recorder against a write-list reference model
module tb_seq_recorder;
   localparam int D = 4;

   logic       CLK_50 = 1'b0;
   logic       reset  = 1'b0;
   logic [5:0] seq_num = '0;
   logic [9:0] SW = '0;
   logic       pb_rec = 1'b1;
   logic       pb_clr = 1'b1;
   logic [3:0] step_num;
   logic       busy, done;

   seq_recorder_if ram_if ();

   seq_recorder #(.DEBOUNCE_CYCLES(D)) dut (
      .CLK_50   (CLK_50),
      .reset    (reset),
      .seq_num  (seq_num),
      .SW       (SW),
      .pb_rec   (pb_rec),
      .pb_clr   (pb_clr),
      .ram      (ram_if.master),
      .step_num (step_num),
      .busy     (busy),
      .done     (done)
   );

   always #10 CLK_50 = ~CLK_50;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Observed side: every RAM write, busy cycle and done pulse outside reset.
   logic [19:0] obs_q[$];
   int  busy_cycles = 0;
   int  done_cnt    = 0;
   int  order_err   = 0;
   bit  prev_busy   = 0;

   always @(negedge CLK_50) begin
      if (!reset) begin
         prev_busy = 0;
      end else begin
         if (ram_if.wren_a) obs_q.push_back({ram_if.address_a, ram_if.data_a});
         if (busy) busy_cycles++;
         if (done) done_cnt++;
         if (done && busy) order_err++;
         if (prev_busy && !busy && !done) order_err++;
         prev_busy = busy;
      end
   end

   // Reference model: list of expected writes plus the next step index.
   logic [19:0] exp_q[$];
   int exp_done = 0;
   int exp_busy = 0;
   int m_step   = 0;

   task automatic tick(input int n);
      repeat (n) @(posedge CLK_50);
      #1;
   endtask

   task automatic set_seq(input logic [5:0] v);
      if (v != seq_num) m_step = 0;
      seq_num = v;
   endtask

   task automatic model_rec();
      logic [3:0] s;
      s = 4'(m_step);
      exp_q.push_back({seq_num, s, SW});
      m_step = (m_step + 1) % 16;
      if (m_step == 0) exp_done++;
   endtask

   task automatic model_clr();
      for (int k = 0; k < 16; k++) exp_q.push_back({seq_num, 4'(k), 10'd0});
      exp_done++;
      exp_busy += 16;
      m_step = 0;
   endtask

   task automatic press_rec(input int hold);
      model_rec();
      pb_rec = 1'b0;
      tick(hold);
      pb_rec = 1'b1;
      tick(16);
   endtask

   task automatic press_clr();
      model_clr();
      pb_clr = 1'b0;
      tick(6);
      pb_clr = 1'b1;
      tick(30);
   endtask

   task automatic bounce(input int n);
      for (int i = 0; i < n; i++) begin
         pb_rec = 1'b0;
         tick($urandom_range(1, D - 1));
         pb_rec = 1'b1;
         tick($urandom_range(1, 3));
      end
      tick(16);
   endtask

   task automatic compare(input string tag);
      chk({tag, "_nwr"}, obs_q.size(), exp_q.size());
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
         chk({tag, "_wr"}, obs_q[i], exp_q[i]);
      chk({tag, "_done"}, done_cnt, exp_done);
      chk({tag, "_busy"}, busy_cycles, exp_busy);
      chk({tag, "_step"}, step_num, m_step);
      obs_q.delete();
      exp_q.delete();
      done_cnt = 0;  exp_done = 0;
      busy_cycles = 0; exp_busy = 0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [5:0] v;
      int n;
      tick(3);
      chk("rst_wren", ram_if.wren_a, 0);
      chk("rst_addr", ram_if.address_a, 0);
      chk("rst_data", ram_if.data_a, 0);
      chk("rst_step", step_num, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      reset = 1'b1;
      tick(2);

      set_seq(6'd3); SW = 10'h2A5;
      press_rec(10);
      chk("t1_step", step_num, 1);
      compare("t1");

      set_seq(6'd5);
      for (int i = 0; i < 16; i++) begin
         SW = 10'(i);
         press_rec(D + 2);
      end
      compare("t2");

      for (int i = 0; i < 10; i++) begin
         pb_rec = 1'b0; tick(2);
         pb_rec = 1'b1; tick(2);
      end
      tick(10);
      compare("t3_bounce");
      SW = 10'h155;
      press_rec(7);
      compare("t3_hold");

      set_seq(6'd63); tick(2);
      model_clr();
      pb_clr = 1'b0; tick(6);
      pb_rec = 1'b0; tick(6);
      pb_rec = 1'b1; pb_clr = 1'b1;
      tick(30);
      compare("t4");

      set_seq(6'd9); tick(2);
      model_clr();
      pb_rec = 1'b0; pb_clr = 1'b0; tick(8);
      pb_rec = 1'b1; pb_clr = 1'b1; tick(30);
      compare("t5_both");

      set_seq(6'd2); tick(2);
      for (int i = 0; i < 3; i++) begin SW = 10'($urandom); press_rec(D + 1); end
      set_seq(6'd4); tick(2);
      SW = 10'h3C3;
      press_rec(D + 1);
      compare("t5_seq");

      SW = 10'h011; press_rec(D + 3);
      set_seq(6'd12); tick(2);
      pb_clr = 1'b0;
      n = 0;
      while (!busy && n < 40) begin @(negedge CLK_50); n++; end
      chk("t6_busy_seen", busy, 1);
      repeat (7) @(negedge CLK_50);
      #5 reset = 1'b0;
      #1;
      chk("t6_wren", ram_if.wren_a, 0);
      chk("t6_busy", busy, 0);
      chk("t6_step", step_num, 0);
      for (int k = 0; k < 8; k++) exp_q.push_back({seq_num, 4'(k), 10'd0});
      exp_busy += 8;
      m_step = 0;
      pb_clr = 1'b1;
      tick(3);
      reset = 1'b1;
      tick(4);
      compare("t6_abort");
      SW = 10'h0F0;
      press_rec(D + 2);
      compare("t6_after");

      for (int it = 0; it < 40; it++) begin
         case ($urandom_range(0, 7))
            0, 1, 2, 3: begin SW = 10'($urandom); press_rec($urandom_range(D + 1, D + 6)); end
            4: bounce($urandom_range(3, 8));
            5: press_clr();
            default: begin
               v = ($urandom_range(0, 3) == 0) ? seq_num : 6'($urandom);
               set_seq(v);
               tick(2);
            end
         endcase
         compare("rnd");
      end

      chk("order", order_err, 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
